// File: rtl/fp_alu_pkg.sv
// Shared encodings, sequencer state type and default latencies for the FP ALU sequencer.
package fp_alu_pkg;

  localparam logic [2:0] ALU_MFC1 = 3'b000;
  localparam logic [2:0] ALU_MTC1 = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_MOV  = 3'b100;
  localparam logic [2:0] ALU_CEQ  = 3'b101;
  localparam logic [2:0] ALU_CLT  = 3'b110;
  localparam logic [2:0] ALU_CLE  = 3'b111;

  localparam int DEF_LAT_ARITH = 3;
  localparam int DEF_LAT_CMP   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fp_op_decode.sv
// Combinational decode of ALUop/functcode into ALU op code, latency class,
// compare flag and legality.
module fp_op_decode
  import fp_alu_pkg::*;
#(
  parameter int LAT_ARITH = DEF_LAT_ARITH,
  parameter int LAT_CMP   = DEF_LAT_CMP
) (
  input  logic [1:0] aluop,
  input  logic [5:0] functcode,
  output logic [2:0] aluctl,
  output logic [3:0] lat,
  output logic       is_cmp,
  output logic       legal
);

  localparam logic [3:0] LAT_A = 4'(LAT_ARITH);
  localparam logic [3:0] LAT_C = 4'(LAT_CMP);

  // op table: unlisted COP1 functs and ALUop=11 fall out as illegal
  always_comb begin
    aluctl = ALU_MFC1;
    lat    = 4'd1;
    is_cmp = 1'b0;
    legal  = 1'b1;
    case (aluop)
      2'b00: aluctl = ALU_MFC1;
      2'b01: aluctl = ALU_MTC1;
      2'b10: begin
        case (functcode)
          6'h00: begin aluctl = ALU_ADD; lat = LAT_A; end
          6'h01: begin aluctl = ALU_SUB; lat = LAT_A; end
          6'h06: aluctl = ALU_MOV;
          6'h32: begin aluctl = ALU_CEQ; lat = LAT_C; is_cmp = 1'b1; end
          6'h30: begin aluctl = ALU_CLT; lat = LAT_C; is_cmp = 1'b1; end
          6'h36: begin aluctl = ALU_CLE; lat = LAT_C; is_cmp = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_alu_sequencer.sv
// Issue/EXEC/WB sequencer for the COP1 FP ALU.
// Optional FP_SEQ_PERF_CNT_EN adds a 32-bit stall_cycles performance counter.
module fp_alu_sequencer
  import fp_alu_pkg::*;
#(
  parameter int LAT_ARITH = DEF_LAT_ARITH,
  parameter int LAT_CMP   = DEF_LAT_CMP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  ALUop,
  input  logic [5:0]  functcode,
  input  logic [4:0]  fd,
  output logic [2:0]  ALUcontrol,
  input  logic        alu_cmp_in,
  output logic        wb_valid,
  output logic        wb_gpr,
  output logic [4:0]  wb_reg,
  output logic        fcc,
  output logic        illegal,
  output logic        stall
`ifdef FP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic [2:0] dec_ctl_s;
  logic [3:0] dec_lat_s;
  logic       dec_cmp_s;
  logic       dec_legal_s;

  seq_state_t state_r, state_next_s;
  logic [3:0] cnt_r, cnt_next_s;
  logic [2:0] aluctl_r;
  logic [4:0] fd_r;
  logic       is_cmp_r;
  logic       wb_valid_r;
  logic       wb_gpr_r;
  logic [4:0] wb_reg_r;
  logic       fcc_r;
  logic       illegal_r;
  logic       accept_s;
  logic       start_s;
  logic       wb_set_s;

  fp_op_decode #(
    .LAT_ARITH (LAT_ARITH),
    .LAT_CMP   (LAT_CMP)
  ) u_decode (
    .aluop     (ALUop),
    .functcode (functcode),
    .aluctl    (dec_ctl_s),
    .lat       (dec_lat_s),
    .is_cmp    (dec_cmp_s),
    .legal     (dec_legal_s)
  );

  assign issue_ready = (state_r != ST_EXEC);
  assign stall       = issue_valid & ~issue_ready;
  assign accept_s    = issue_valid & issue_ready;
  assign start_s     = accept_s & dec_legal_s;
  assign wb_set_s    = (state_r == ST_EXEC) && (cnt_r == 4'd0) && !is_cmp_r;

  // next-state and latency counter
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_WB: begin
        if (start_s) begin
          state_next_s = ST_EXEC;
          cnt_next_s   = dec_lat_s - 4'd1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_WB;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // latched op and registered result/flag outputs; wb strobe is armed on EXEC exit
  always_ff @(posedge clk) begin
    if (reset) begin
      aluctl_r   <= ALU_MFC1;
      fd_r       <= 5'd0;
      is_cmp_r   <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_gpr_r   <= 1'b0;
      wb_reg_r   <= 5'd0;
      fcc_r      <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      if (start_s) begin
        aluctl_r <= dec_ctl_s;
        fd_r     <= fd;
        is_cmp_r <= dec_cmp_s;
      end
      wb_valid_r <= wb_set_s;
      wb_gpr_r   <= wb_set_s && (aluctl_r == ALU_MFC1);
      if (wb_set_s) begin
        wb_reg_r <= fd_r;
      end
      if ((state_r == ST_WB) && is_cmp_r) begin
        fcc_r <= alu_cmp_in;
      end
      illegal_r <= accept_s & ~dec_legal_s;
    end
  end

  // a reset landing on the WB cycle must suppress the strobe already armed
  assign wb_valid   = wb_valid_r & ~reset;
  assign wb_gpr     = wb_gpr_r;
  assign wb_reg     = wb_reg_r;
  assign fcc        = fcc_r;
  assign illegal    = illegal_r;
  assign ALUcontrol = aluctl_r;

`ifdef FP_SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // counts cycles an offered op is held off; wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Self-checking bench for fp_alu_sequencer: timing model plus literal checks.
module tb_fp_alu_sequencer;

  localparam int LA = 3;
  localparam int LC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  ALUop;
  logic [5:0]  functcode;
  logic [4:0]  fd;
  logic [2:0]  ALUcontrol;
  logic        alu_cmp_in;
  logic        wb_valid;
  logic        wb_gpr;
  logic [4:0]  wb_reg;
  logic        fcc;
  logic        illegal;
  logic        stall;
`ifdef FP_SEQ_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  fp_alu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .ALUop        (ALUop),
    .functcode    (functcode),
    .fd           (fd),
    .ALUcontrol   (ALUcontrol),
    .alu_cmp_in   (alu_cmp_in),
    .wb_valid     (wb_valid),
    .wb_gpr       (wb_gpr),
    .wb_reg       (wb_reg),
    .fcc          (fcc),
    .illegal      (illegal),
    .stall        (stall)
`ifdef FP_SEQ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference op table
  typedef struct packed {
    logic [2:0] ctl;
    int         lat;
    bit         cmp;
    bit         ok;
  } dec_t;

  function automatic dec_t spec_decode(input logic [1:0] op, input logic [5:0] fn);
    dec_t d;
    d = '{ctl: 3'd0, lat: 1, cmp: 1'b0, ok: 1'b1};
    if (op == 2'b00)      d.ctl = 3'b000;
    else if (op == 2'b01) d.ctl = 3'b001;
    else if (op == 2'b10) begin
      case (fn)
        6'h00: begin d.ctl = 3'b010; d.lat = LA; end
        6'h01: begin d.ctl = 3'b011; d.lat = LA; end
        6'h06: d.ctl = 3'b100;
        6'h32: begin d.ctl = 3'b101; d.lat = LC; d.cmp = 1'b1; end
        6'h30: begin d.ctl = 3'b110; d.lat = LC; d.cmp = 1'b1; end
        6'h36: begin d.ctl = 3'b111; d.lat = LC; d.cmp = 1'b1; end
        default: d.ok = 1'b0;
      endcase
    end else d.ok = 1'b0;
    return d;
  endfunction

  // Timing model: an op accepted at cycle c is busy c+1..c+lat and writes back at c+lat+1
  int          acc_cycle = -1;
  int          wb_cycle  = -1;
  int          ill_cycle = -1;
  bit          m_cmp     = 1'b0;
  logic [4:0]  m_fd      = 5'd0;
  logic [2:0]  m_ctl     = 3'd0;
  logic        m_fcc     = 1'b0;
  logic [31:0] m_stall   = 32'd0;
  dec_t        d_s;

  always_comb d_s = spec_decode(ALUop, functcode);

  function automatic bit m_ready(input int c);
    return !(c > acc_cycle && c < wb_cycle);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      acc_cycle <= -1;
      wb_cycle  <= -1;
      ill_cycle <= -1;
      m_cmp     <= 1'b0;
      m_ctl     <= 3'd0;
      m_fcc     <= 1'b0;
      m_stall   <= 32'd0;
    end else begin
      if (issue_valid && !m_ready(cyc)) m_stall <= m_stall + 32'd1;
      if (cyc == wb_cycle && m_cmp) m_fcc <= alu_cmp_in;
      if (issue_valid && m_ready(cyc)) begin
        if (!d_s.ok) ill_cycle <= cyc + 1;
        else begin
          m_ctl     <= d_s.ctl;
          acc_cycle <= cyc;
          wb_cycle  <= cyc + d_s.lat + 1;
          m_cmp     <= d_s.cmp;
          m_fd      <= fd;
        end
      end
    end
    cyc <= cyc + 1;
  end

  logic exp_ready, exp_wb;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_ready = m_ready(cyc);
      exp_wb    = (cyc == wb_cycle) && !m_cmp && !reset;
      chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
      chk("stall", 32'(stall), 32'(issue_valid && !exp_ready));
      chk("wb_valid", 32'(wb_valid), 32'(exp_wb));
      if (exp_wb) begin
        chk("wb_gpr", 32'(wb_gpr), 32'(m_ctl == 3'b000));
        chk("wb_reg", 32'(wb_reg), 32'(m_fd));
      end
      chk("ALUcontrol", 32'(ALUcontrol), 32'(m_ctl));
      chk("fcc", 32'(fcc), 32'(m_fcc));
      chk("illegal", 32'(illegal), 32'(cyc == ill_cycle));
`ifdef FP_SEQ_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn, input logic [4:0] d);
    issue_valid = v;
    ALUop       = op;
    functcode   = fn;
    fd          = d;
  endtask

  initial begin
    reset      = 1'b1;
    alu_cmp_in = 1'b0;
    drive(1'b1, 2'b01, 6'h00, 5'd1);  // ignored while in reset
    step(2);
    reset = 1'b0;
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_ctl", 32'(ALUcontrol), 32'd0);
    chk("rst_wb", 32'(wb_valid), 32'd0);
    chk("rst_wbreg", 32'(wb_reg), 32'd0);
    chk("rst_fcc", 32'(fcc), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);

    // add.s fd=5 accepted at cycle 0
    drive(1'b1, 2'b10, 6'h00, 5'd5);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    chk("add_c1_ctl", 32'(ALUcontrol), 32'd2);
    chk("add_c1_ready", 32'(issue_ready), 32'd0);
    step(2);
    chk("add_c3_ready", 32'(issue_ready), 32'd0);
    step(1);
    chk("add_c4_wb", 32'(wb_valid), 32'd1);
    chk("add_c4_reg", 32'(wb_reg), 32'd5);
    chk("add_c4_ctl", 32'(ALUcontrol), 32'd2);
    chk("add_c4_ready", 32'(issue_ready), 32'd1);
    step(1);
    chk("add_c5_wb", 32'(wb_valid), 32'd0);

    // c.lt.s true then c.eq.s false
    alu_cmp_in = 1'b1;
    drive(1'b1, 2'b10, 6'h30, 5'd1);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    step(2);
    chk("clt_wb", 32'(wb_valid), 32'd0);
    step(1);
    chk("clt_fcc", 32'(fcc), 32'd1);
    alu_cmp_in = 1'b0;
    drive(1'b1, 2'b10, 6'h32, 5'd2);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    step(3);
    chk("ceq_fcc", 32'(fcc), 32'd0);

    // mfc1 fd=9 with mov.s fd=3 back-to-back in its WB cycle
    drive(1'b1, 2'b00, 6'h00, 5'd9);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    step(1);
    chk("mfc1_wb", 32'(wb_valid), 32'd1);
    chk("mfc1_gpr", 32'(wb_gpr), 32'd1);
    chk("mfc1_reg", 32'(wb_reg), 32'd9);
    drive(1'b1, 2'b10, 6'h06, 5'd3);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    chk("mov_ctl", 32'(ALUcontrol), 32'd4);
    step(1);
    chk("mov_wb", 32'(wb_valid), 32'd1);
    chk("mov_gpr", 32'(wb_gpr), 32'd0);
    chk("mov_reg", 32'(wb_reg), 32'd3);

    // illegal COP1 funct and illegal ALUop
    step(1);
    drive(1'b1, 2'b10, 6'h05, 5'd4);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_ready", 32'(issue_ready), 32'd1);
    step(1);
    chk("ill_clear", 32'(illegal), 32'd0);
    drive(1'b1, 2'b11, 6'h00, 5'd4);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    chk("ill11_pulse", 32'(illegal), 32'd1);

    // sub.s aborted by reset at its cycle 2, then mtc1 fd=12
    step(1);
    drive(1'b1, 2'b10, 6'h01, 5'd7);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("abort_ctl", 32'(ALUcontrol), 32'd0);
    chk("abort_ready", 32'(issue_ready), 32'd1);
    chk("abort_wbreg", 32'(wb_reg), 32'd0);
    step(4);
    drive(1'b1, 2'b01, 6'h00, 5'd12);
    step(1);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    step(1);
    chk("mtc1_wb", 32'(wb_valid), 32'd1);
    chk("mtc1_gpr", 32'(wb_gpr), 32'd0);
    chk("mtc1_reg", 32'(wb_reg), 32'd12);

`ifdef FP_SEQ_PERF_CNT_EN
    // issue_valid held through an add.s: three EXEC stall cycles
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    drive(1'b1, 2'b10, 6'h00, 5'd6);
    step(4);
    drive(1'b0, 2'b00, 6'h00, 5'd0);
    chk("perf_stalls", stall_cycles, 32'd3);
`endif

    step(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_alu_sequencer.md
FP_ALU_SEQUENCER -- requirements
Module: fp_alu_sequencer

Interface
REQ-001 SHALL have parameter LAT_ARITH, default 3, cycles in EXEC for add.s/sub.s (legal range 1..15).
REQ-002 SHALL have parameter LAT_CMP, default 2, cycles in EXEC for c.eq.s/c.lt.s/c.le.s (legal range 1..15).
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  sequencer can accept.
- ALUop  in  2  00 mfc1, 01 mtc1, 10 COP1 arithmetic/compare, 11 illegal.
- functcode  in  6  COP1 funct field.
- fd  in  5  destination register.
- ALUcontrol  out  3  op code driven to the FP ALU.
- alu_cmp_in  in  1  compare result from the FP ALU.
- wb_valid  out  1  one-cycle result write strobe.
- wb_gpr  out  1  with wb_valid: 1 = GPR target (mfc1), 0 = FPR target.
- wb_reg  out  5  write destination.
- fcc  out  1  FP condition flag.
- illegal  out  1  one-cycle illegal-op pulse.
- stall  out  1  issue_valid && !issue_ready.

Function
REQ-004 SHALL decode: mfc1→000, mtc1→001, add.s (6'h00)→010, sub.s (6'h01)→011, mov.s (6'h06)→100, c.eq.s (6'h32)→101, c.lt.s (6'h30)→110, c.le.s (6'h36)→111.
REQ-005 SHALL set latency class: 1 cycle for mfc1/mtc1/mov.s, LAT_ARITH for add/sub, LAT_CMP for compares.
REQ-006 SHALL implement states IDLE, EXEC and WB; issue_ready SHALL be 1 in IDLE and WB and 0 in EXEC.
REQ-007 SHALL accept a legal op on issue_valid && issue_ready, which latches ALUcontrol, fd and the compare flag and enters EXEC with the counter loaded to latency-1.
REQ-008 SHALL hold ALUcontrol stable from the cycle after accept through the WB cycle.
REQ-009 SHALL decrement the counter in EXEC and move EXEC→WB when the counter is 0.
REQ-010 SHALL therefore spend exactly latency cycles in EXEC, with WB on cycle latency+1 after accept.
REQ-011 SHALL, in WB for a non-compare op, pulse wb_valid for one cycle with wb_reg = latched fd and wb_gpr = (op==mfc1).
REQ-012 SHALL, in WB for a compare op, keep wb_valid at 0 and load fcc from alu_cmp_in sampled in that cycle.
REQ-013 SHALL, on WB with a simultaneous accept, go directly to EXEC for the new op (back-to-back, no IDLE bubble); otherwise WB→IDLE.
REQ-014 SHALL treat ALUop=11, or ALUop=10 with an unlisted functcode, as illegal when accepted.
REQ-015 SHALL, for an illegal op: pulse illegal for one cycle, generate no EXEC/WB activity, leave the state at IDLE and keep issue_ready at 1.
REQ-016 SHALL hold ALUcontrol at its previous value when idle.

Reset
REQ-017 SHALL, on reset, go to IDLE and clear the counter; issue_ready=1, ALUcontrol=000, wb_valid=0, wb_gpr=0, wb_reg=0, fcc=0, illegal=0.
REQ-018 SHALL, on reset asserted mid-EXEC or in WB, abort the in-flight op: no wb_valid and no fcc update.
REQ-019 SHALL ignore issue_valid during reset.

Configuration
REQ-020 SHALL, with FP_SEQ_PERF_CNT_EN defined, add a 32-bit output stall_cycles: it increments each cycle stall=1, wraps 0xFFFFFFFF→0, and is cleared by reset.
REQ-021 SHALL, without FP_SEQ_PERF_CNT_EN, have no stall_cycles port and no counter logic; all other behaviour is identical.

Structure
REQ-022 SHALL place the ALUcontrol encodings, the state enum and the default latencies in the shared package fp_alu_pkg.
REQ-023 SHALL place the combinational decode (ALUop/functcode → ALUcontrol, latency class, is_cmp, legal) in a single sub-module, fp_op_decode.

Verification
REQ-024 SHALL cover: reset, then add.s fd=5 accepted at cycle 0 with LAT_ARITH=3 → ALUcontrol=010 cycles 1-4, issue_ready=0 cycles 1-3, wb_valid=1 with wb_reg=5 at cycle 4 only.
REQ-025 SHALL cover: c.lt.s with alu_cmp_in=1 in WB → fcc=1 from the next cycle, wb_valid never 1; a following c.eq.s with alu_cmp_in=0 → fcc=0.
REQ-026 SHALL cover: mfc1 fd=9, then mov.s presented in its WB cycle → wb_valid/wb_gpr=1/wb_reg=9, then mov.s accepted in the same cycle and its WB two cycles later with wb_gpr=0.
REQ-027 SHALL cover: ALUop=10 with functcode=6'h05 → illegal=1 for one cycle, issue_ready stays 1, no wb_valid.
REQ-028 SHALL cover: reset asserted at cycle 2 of a sub.s → no wb_valid ever; after reset, all outputs at reset values and an mtc1 completes normally.
REQ-029 SHALL cover, with FP_SEQ_PERF_CNT_EN: issue_valid held through one add.s (3 stall cycles) → stall_cycles=3.
